axis_ramp_sched: RTL and testbench

Time-multiplexed acceleration limiter placed between the serial speed-command decoder and the six step generators. It ramps each axis's current speed toward its commanded target by at most ACCEL per update tick. One shared subtract/compare/add datapath is sequenced axis-by-axis once per tick, which keeps step-rate changes bounded when joystick frames jump.

---
 rtl/axis_ramp_sched.sv | 219 +++++++++++++++++++++
 tb/tb_axis_ramp_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ramp_sched.sv
// Per-tick acceleration limiter: one shared subtract/compare/add datapath swept over all axes.
// Optional watchdog (zero targets after WDOG_TICKS silent ticks): define AXIS_RAMP_WATCHDOG_EN.

module axis_ramp_sched #(
    parameter int unsigned NUM_AXES   = 6,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned WDOG_TICKS = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   tgt_valid,
    input  logic [32*NUM_AXES-1:0] tgt_flat,
    input  logic [31:0]            accel,
    output logic [32*NUM_AXES-1:0] cur_flat,
    output logic [NUM_AXES-1:0]    at_target,
    output logic                   busy,
    output logic                   sweep_done,
    output logic                   overrun,
    output logic                   wdog_trip
);

    localparam int unsigned SPD_W = 32;
    localparam int unsigned IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_CALC,
        S_WB,
        S_DONE
    } state_e;

    typedef logic [NUM_AXES-1:0][SPD_W-1:0] spd_vec_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               tick_c;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    spd_vec_t           shadow_q, shadow_d;
    spd_vec_t           work_q, work_d;
    spd_vec_t           cur_q, cur_d;
    logic [SPD_W-1:0]   next_q, next_d;
    logic [NUM_AXES-1:0] at_q, at_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SPD_W-1:0]   cur_sel_c;
    logic [SPD_W-1:0]   tgt_sel_c;
    logic [SPD_W:0]     diff_c;
    logic [SPD_W:0]     mag_c;
    logic [SPD_W:0]     acc_c;
    logic [SPD_W-1:0]   step_c;
    logic               unused_c;

    // Free-running tick divider, independent of the sweep FSM.
    always_comb begin
        tick_c     = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
    end

    // Shared ramp step; 33-bit difference keeps opposite-sign extremes from wrapping.
    always_comb begin
        cur_sel_c = cur_q[idx_q];
        tgt_sel_c = work_q[idx_q];
        diff_c    = {tgt_sel_c[SPD_W-1], tgt_sel_c} - {cur_sel_c[SPD_W-1], cur_sel_c};
        mag_c     = diff_c[SPD_W] ? (~diff_c + (SPD_W+1)'(1)) : diff_c;
        acc_c     = {2'b00, accel[SPD_W-2:0]};
        if (mag_c <= acc_c) begin
            step_c = tgt_sel_c;
        end else if (!diff_c[SPD_W]) begin
            step_c = cur_sel_c + acc_c[SPD_W-1:0];
        end else begin
            step_c = cur_sel_c - acc_c[SPD_W-1:0];
        end
    end

    // Sweep sequencer and tick bookkeeping.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        idx_d     = idx_q;
        work_d    = work_q;
        cur_d     = cur_q;
        next_d    = next_q;
        at_d      = at_q;

        if (tick_c && (state_q != S_IDLE)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_c || pending_q) begin
                    state_d   = S_SNAP;
                    pending_d = 1'b0;
                end
            end
            S_SNAP: begin
                work_d  = enable ? shadow_q : '0;
                idx_d   = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                next_d  = step_c;
                state_d = S_WB;
            end
            S_WB: begin
                cur_d[idx_q] = next_q;
                at_d[idx_q]  = (next_q == work_q[idx_q]);
                if (idx_q == IDX_W'(NUM_AXES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            idx_q      <= '0;
            shadow_q   <= '0;
            work_q     <= '0;
            cur_q      <= '0;
            next_q     <= '0;
            at_q       <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            work_q     <= work_d;
            cur_q      <= cur_d;
            next_q     <= next_d;
            at_q       <= at_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef AXIS_RAMP_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_TICKS + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            trip_q, trip_d;

    // Silent-link watchdog; a same-cycle tgt_valid takes priority over a trip.
    always_comb begin
        shadow_d = shadow_q;
        wd_cnt_d = wd_cnt_q;
        trip_d   = trip_q;
        if (tgt_valid) begin
            shadow_d = tgt_flat;
            wd_cnt_d = '0;
            trip_d   = 1'b0;
        end else if (tick_c && !trip_q) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            if (wd_cnt_d == WD_W'(WDOG_TICKS)) begin
                trip_d   = 1'b1;
                shadow_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            trip_q   <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            trip_q   <= trip_d;
        end
    end

    assign wdog_trip = trip_q;
`else
    always_comb begin
        shadow_d = tgt_valid ? tgt_flat : shadow_q;
    end

    assign wdog_trip = 1'b0;
`endif

    // accel[31] is deliberately ignored; WDOG_TICKS only matters with the watchdog built in.
    assign unused_c = accel[SPD_W-1] ^ (WDOG_TICKS == 32'd0);

    assign cur_flat   = cur_q;
    assign at_target  = at_q;
    assign busy       = busy_q;
    assign sweep_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_axis_ramp_sched.sv
// Scoreboard bench for axis_ramp_sched: a behavioural ramp model predicts each sweep's result.
module tb_axis_ramp_sched;

    localparam int unsigned NA   = 6;
    localparam int          WDOG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, rst2_n, enable, tgt_valid;
    logic [32*NA-1:0] tgt_flat;
    logic [31:0]     accel;
    logic [32*NA-1:0] cur_flat, cur2;
    logic [NA-1:0]   at_target, at2;
    logic            busy, sweep_done, overrun, wdog_trip;
    logic            busy2, sd2, ov2, wd2;

    axis_ramp_sched #(.NUM_AXES(NA), .TICK_DIV(20), .WDOG_TICKS(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tgt_valid(tgt_valid),
        .tgt_flat(tgt_flat), .accel(accel), .cur_flat(cur_flat),
        .at_target(at_target), .busy(busy), .sweep_done(sweep_done),
        .overrun(overrun), .wdog_trip(wdog_trip)
    );

    axis_ramp_sched #(.NUM_AXES(NA), .TICK_DIV(5), .WDOG_TICKS(WDOG)) dut_fast (
        .clk(clk), .rst_n(rst2_n), .enable(enable), .tgt_valid(tgt_valid),
        .tgt_flat(tgt_flat), .accel(accel), .cur_flat(cur2),
        .at_target(at2), .busy(busy2), .sweep_done(sd2),
        .overrun(ov2), .wdog_trip(wd2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [32*NA-1:0] cur;
        logic [NA-1:0]    at;
    } exp_t;
    exp_t sb_q[$];

    longint m_cur[NA];
    longint m_sh[NA];
`ifdef AXIS_RAMP_WATCHDOG_EN
    int m_wd;
    bit m_trip;
`endif

    function automatic longint ramp(input longint c, input longint t, input longint a);
        longint d;
        d = t - c;
        if (d <= a && d >= -a) return t;
        if (d > 0) return c + a;
        return c - a;
    endfunction

    // Predict n consecutive sweeps from the current enable/accel/shadow.
    task automatic push_sweep(input int n);
        exp_t   e;
        longint acc, t, nv;
        for (int s = 0; s < n; s++) begin
`ifdef AXIS_RAMP_WATCHDOG_EN
            if (!m_trip) begin
                m_wd++;
                if (m_wd == WDOG) begin
                    m_trip = 1'b1;
                    for (int i = 0; i < NA; i++) m_sh[i] = 0;
                end
            end
`endif
            acc = longint'(accel & 32'h7FFF_FFFF);
            for (int i = 0; i < NA; i++) begin
                t  = enable ? m_sh[i] : 0;
                nv = ramp(m_cur[i], t, acc);
                m_cur[i] = nv;
                e.cur[32*i +: 32] = nv[31:0];
                e.at[i] = (nv == t);
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic send_tgt();
        longint v;
        @(posedge clk); #1;
        for (int i = 0; i < NA; i++) begin
            v = m_sh[i];
            tgt_flat[32*i +: 32] = v[31:0];
        end
        tgt_valid = 1'b1;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
`ifdef AXIS_RAMP_WATCHDOG_EN
        m_wd   = 0;
        m_trip = 1'b0;
`endif
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sweep_done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_busy(output bit to);
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Scoreboard: every sweep_done pops one predicted sweep.
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (rst_n && sweep_done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sweep_unexpected: got cur=%h, required no sweep", cur_flat);
            end else begin
                e = sb_q.pop_front();
                if (cur_flat !== e.cur) begin
                    errors++;
                    $display("FAIL sweep_cur: got %h, required %h", cur_flat, e.cur);
                end
                checks++;
                if (at_target !== e.at) begin
                    errors++;
                    $display("FAIL sweep_at: got %b, required %b", at_target, e.at);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0; enable = 1'b1; tgt_valid = 1'b0;
        tgt_flat = '0; accel = 32'd100;
        for (int i = 0; i < NA; i++) begin m_cur[i] = 0; m_sh[i] = 0; end
`ifdef AXIS_RAMP_WATCHDOG_EN
        m_wd = 0; m_trip = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cur_flat !== '0) begin errors++; $display("FAIL reset_cur: got %h, required 0", cur_flat); end
        checks++;
        if (at_target !== 6'b111111) begin errors++; $display("FAIL reset_at: got %b, required 111111", at_target); end
        checks++;
        if ({busy, sweep_done, overrun, wdog_trip} !== 4'b0000)
            begin errors++; $display("FAIL reset_flags: got %b, required 0000", {busy, sweep_done, overrun, wdog_trip}); end
        checks++;
        if ({busy2, sd2, ov2, wd2} !== 4'b0000)
            begin errors++; $display("FAIL reset_flags_fast: got %b, required 0000", {busy2, sd2, ov2, wd2}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        bit to;
        m_sh[0] = 250;
        send_tgt();
        push_sweep(3);
        for (int s = 0; s < 3; s++) begin
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL ramp_up_timeout: got no sweep_done, required sweep %0d", s); end
        end
        checks++;
        if (at_target[0] !== 1'b1) begin errors++; $display("FAIL ramp_up_at_x: got %b, required 1", at_target[0]); end
    endtask

    task automatic test_ramp_down();
        bit          to, busy_at;
        int          cx, n;
        logic [31:0] x0;
        m_sh[0] = -50;
        send_tgt();
        push_sweep(3);
        wait_busy(to);
        checks++;
        if (to) begin errors++; $display("FAIL down_busy_timeout: got busy=0, required 1"); end
        x0 = cur_flat[31:0]; cx = -1; n = -1; busy_at = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (cx < 0 && cur_flat[31:0] !== x0) cx = k;
            if (sweep_done) begin n = k; busy_at = busy; break; end
        end
        checks++;
        if (cx != 3) begin errors++; $display("FAIL down_x_latency: got %0d, required 3", cx); end
        checks++;
        if (n != 14) begin errors++; $display("FAIL down_done_latency: got %0d, required 14", n); end
        checks++;
        if (busy_at !== 1'b0) begin errors++; $display("FAIL down_busy_at_done: got %b, required 0", busy_at); end
        @(negedge clk);
        checks++;
        if (sweep_done !== 1'b0) begin errors++; $display("FAIL down_done_pulse: got %b, required 0", sweep_done); end
        for (int s = 0; s < 2; s++) begin
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL down_timeout: got no sweep_done, required sweep %0d", s); end
        end
    endtask

    task automatic test_midsweep();
        bit to;
        push_sweep(1);
        wait_busy(to);
        checks++;
        if (to) begin errors++; $display("FAIL mid_busy_timeout: got busy=0, required 1"); end
        m_sh[1] = 1000;
        send_tgt();
        push_sweep(1);
        for (int s = 0; s < 2; s++) begin
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL mid_timeout: got no sweep_done, required sweep %0d", s); end
        end
        checks++;
        if (cur_flat[63:32] !== 32'd100) begin errors++; $display("FAIL mid_y: got %0d, required 100", cur_flat[63:32]); end
    endtask

    task automatic test_disable();
        bit to;
        accel = 32'd300;
        m_sh[2] = 300;
        send_tgt();
        push_sweep(1);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL dis_setup_timeout: got no sweep_done, required one"); end
        enable = 1'b0;
        accel  = 32'd100;
        push_sweep(3);
        for (int s = 0; s < 3; s++) begin
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL dis_timeout: got no sweep_done, required sweep %0d", s); end
        end
        checks++;
        if (cur_flat[95:64] !== 32'd0) begin errors++; $display("FAIL dis_z: got %0d, required 0", cur_flat[95:64]); end
        checks++;
        if (at_target[2] !== 1'b1) begin errors++; $display("FAIL dis_at_z: got %b, required 1", at_target[2]); end
    endtask

    task automatic test_accel_zero();
        bit to;
        enable = 1'b1;
        accel  = 32'h8000_0000;
        push_sweep(2);
        for (int s = 0; s < 2; s++) begin
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL acc0_timeout: got no sweep_done, required sweep %0d", s); end
        end
    endtask

`ifdef AXIS_RAMP_WATCHDOG_EN
    task automatic test_watchdog();
        bit to;
        accel = 32'd100;
        for (int i = 0; i < NA; i++) m_sh[i] = 0;
        m_sh[0] = 200;
        send_tgt();
        push_sweep(3);
        for (int s = 0; s < 3; s++) begin
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL wd_timeout: got no sweep_done, required sweep %0d", s); end
        end
        checks++;
        if (wdog_trip !== 1'b0) begin errors++; $display("FAIL wd_early: got %b, required 0", wdog_trip); end
        push_sweep(2);
        wait_done(to);
        checks++;
        if (wdog_trip !== 1'b1) begin errors++; $display("FAIL wd_trip: got %b, required 1", wdog_trip); end
        wait_done(to);
        checks++;
        if (cur_flat[31:0] !== 32'd0) begin errors++; $display("FAIL wd_x_zero: got %0d, required 0", cur_flat[31:0]); end
        send_tgt();
        checks++;
        if (wdog_trip !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b, required 0", wdog_trip); end
    endtask
`endif

    task automatic test_extremes();
        bit to;
        enable  = 1'b1;
        accel   = 32'hFFFF_FFFF;
        m_sh[0] = -64'sd2147483648;
        send_tgt();
        push_sweep(2);
        for (int s = 0; s < 2; s++) begin
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL ext_neg_timeout: got no sweep_done, required sweep %0d", s); end
        end
        m_sh[0] = 64'sd2147483647;
        send_tgt();
        push_sweep(3);
        for (int s = 0; s < 3; s++) begin
            wait_done(to);
            checks++;
            if (to) begin errors++; $display("FAIL ext_pos_timeout: got no sweep_done, required sweep %0d", s); end
        end
        checks++;
        if (cur_flat[31:0] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ext_x_max: got %h, required 7fffffff", cur_flat[31:0]); end
    endtask

    task automatic test_quiesce();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL main_overrun: got %b, required 0", overrun); end
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries, required 0", sb_q.size()); end
        rst_n = 1'b0;
    endtask

    task automatic test_overrun();
        bit to;
        @(posedge clk); #1;
        rst2_n = 1'b1;
        for (int i = 0; i < NA; i++) m_sh[i] = 0;
        m_sh[0] = 500;
        send_tgt();
        checks++;
        if (ov2 !== 1'b0) begin errors++; $display("FAIL ovr_start: got %b, required 0", ov2); end
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sd2) begin to = 1'b0; break; end
        end
        checks++;
        if (to) begin errors++; $display("FAIL ovr_done_timeout: got no sweep_done, required one"); end
        checks++;
        if (ov2 !== 1'b1) begin errors++; $display("FAIL ovr_first_sweep: got %b, required 1", ov2); end
        checks++;
        if (cur2[31:0] !== 32'd500) begin errors++; $display("FAIL ovr_x: got %0d, required 500", cur2[31:0]); end
        repeat (30) @(negedge clk);
        checks++;
        if (ov2 !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b, required 1", ov2); end
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy2) begin to = 1'b0; break; end
        end
        checks++;
        if (to) begin errors++; $display("FAIL ovr_busy_timeout: got busy=0, required 1"); end
        @(posedge clk); #2;
        rst2_n = 1'b0;
        #1;
        checks++;
        if (cur2 !== '0) begin errors++; $display("FAIL ovr_rst_cur: got %h, required 0", cur2); end
        checks++;
        if (at2 !== 6'b111111) begin errors++; $display("FAIL ovr_rst_at: got %b, required 111111", at2); end
        checks++;
        if ({busy2, sd2, ov2, wd2} !== 4'b0000)
            begin errors++; $display("FAIL ovr_rst_flags: got %b, required 0000", {busy2, sd2, ov2, wd2}); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_midsweep();
        test_disable();
        test_accel_zero();
`ifdef AXIS_RAMP_WATCHDOG_EN
        test_watchdog();
`endif
        test_extremes();
        test_quiesce();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
